// File: rtl/seq_pattern_gen_pkg.sv
// rtl/seq_pattern_gen_pkg.sv - shared state type and constants for the serial pattern generator
package seq_gen_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_e;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1001;
  localparam int         MIN_PAT_W       = 2;

  // Bit-index width; kept at least one bit wide for the shortest legal pattern.
  function automatic int idx_w(input int pat_w);
    return (pat_w <= MIN_PAT_W) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// rtl/seq_pattern_gen_if.sv - burst request and serial output bundle of the pattern generator
interface seq_pattern_gen_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             busy;
  logic             x_out;
  logic             x_valid;
  logic             frame_end;
  logic             done;
  logic [CNT_W-1:0] frames_sent;

  modport master (
    output start, pattern, repeat_cnt, gap_len,
    input  busy, x_out, x_valid, frame_end, done, frames_sent
  );

  modport slave (
    input  start, pattern, repeat_cnt, gap_len,
    output busy, x_out, x_valid, frame_end, done, frames_sent
  );
endinterface

// File: rtl/seq_pattern_gen_bit_counter.sv
// rtl/seq_pattern_gen_bit_counter.sv - loadable down-counter for bit index and gap timing
module seq_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - emits a latched bit pattern MSB-first, N frames with optional idle gaps
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_pattern_gen_if.slave   bus
);

  localparam int              IDX_W     = idx_w(PAT_W);
  // The MSB goes out on the load edge itself, so the index counter starts one below it.
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(PAT_W - 2);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             frame_end_q, frame_end_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             idx_load, idx_en, gap_load, gap_en, begin_frame, last_frame;
  logic [IDX_W-1:0] idx_q;
  logic [GAP_W-1:0] gap_q;

  seq_bit_counter #(.W(IDX_W)) u_idx_cnt (
    .clk(clk), .rst(rst), .load(idx_load), .load_val(IDX_FIRST), .en(idx_en), .count(idx_q)
  );

  seq_bit_counter #(.W(GAP_W)) u_gap_cnt (
    .clk(clk), .rst(rst), .load(gap_load), .load_val(gap_len_q), .en(gap_en), .count(gap_q)
  );

  assign last_frame = ({1'b0, frames_q} + 1'b1) == {1'b0, cnt_q};

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    gap_len_d   = gap_len_q;
    frames_d    = frames_q;
    x_out_d     = 1'b0;
    x_valid_d   = 1'b0;
    frame_end_d = 1'b0;
    done_d      = 1'b0;
    busy_d      = 1'b0;
    idx_load    = 1'b0;
    idx_en      = 1'b0;
    gap_load    = 1'b0;
    gap_en      = 1'b0;
    begin_frame = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pat_d     = bus.pattern;
          cnt_d     = bus.repeat_cnt;
          gap_len_d = bus.gap_len;
          frames_d  = '0;
          if (bus.repeat_cnt == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            begin_frame = 1'b1;
          end
        end
      end
      SEND: begin
        if (frame_end_q) begin
          frames_d = (frames_q == '1) ? frames_q : frames_q + 1'b1;
          if (last_frame) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else if (gap_len_q == '0) begin
            begin_frame = 1'b1;
          end else begin
            state_d  = GAP;
            gap_load = 1'b1;
            busy_d   = 1'b1;
          end
        end else begin
          x_out_d     = pat_q[idx_q];
          x_valid_d   = 1'b1;
          frame_end_d = (idx_q == '0);
          idx_en      = 1'b1;
          busy_d      = 1'b1;
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (gap_q <= GAP_W'(1)) begin
          begin_frame = 1'b1;
        end else begin
          gap_en = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (begin_frame) begin
      state_d   = SEND;
      idx_load  = 1'b1;
      x_out_d   = pat_d[PAT_W-1];
      x_valid_d = 1'b1;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      cnt_q       <= '0;
      gap_len_q   <= '0;
      frames_q    <= '0;
      x_out_q     <= 1'b0;
      x_valid_q   <= 1'b0;
      frame_end_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      gap_len_q   <= gap_len_d;
      frames_q    <= frames_d;
      x_out_q     <= x_out_d;
      x_valid_q   <= x_valid_d;
      frame_end_q <= frame_end_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.x_out       = x_out_q;
  assign bus.x_valid     = x_valid_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.frames_sent = frames_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - scoreboard bench for 4-bit and 6-bit pattern generator instances
module tb_seq_pattern_gen;
  import seq_gen_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_pattern_gen_if #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) bus4 ();
  seq_pattern_gen_if #(.PAT_W(6), .CNT_W(8), .GAP_W(4)) bus6 ();

  seq_pattern_gen #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  seq_pattern_gen #(.PAT_W(6), .CNT_W(8), .GAP_W(4)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  typedef struct {
    int         stamp;
    logic       xv, xo, fe, dn, bs;
    logic [7:0] fs;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  cyc    = 0;
  int  checks = 0;
  int  passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s ch%0d @cyc %0d: got 0x%0h expected 0x%0h", name, ch, cyc, act, exp);
  endtask

  task automatic mon(input int ch, input logic xv, input logic xo, input logic fe,
                     input logic dn, input logic bs, input logic [7:0] fs);
    ev_t e;
    int  n;
    if (xv !== 1'b1) chk("x_out_idle", ch, 32'(xo), 32'd0);
    if (xv === 1'b1 || dn === 1'b1) begin
      n = (ch == 0) ? q0.size() : q1.size();
      if (n == 0) begin
        chk("unexpected_output", ch, 32'({xv, dn}), 32'd0);
      end else begin
        if (ch == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        chk("stamp",       ch, 32'(cyc), 32'(e.stamp));
        chk("x_valid",     ch, 32'(xv),  32'(e.xv));
        chk("x_out",       ch, 32'(xo),  32'(e.xo));
        chk("frame_end",   ch, 32'(fe),  32'(e.fe));
        chk("done",        ch, 32'(dn),  32'(e.dn));
        chk("busy",        ch, 32'(bs),  32'(e.bs));
        chk("frames_sent", ch, 32'(fs),  32'(e.fs));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus4.x_valid, bus4.x_out, bus4.frame_end, bus4.done, bus4.busy, bus4.frames_sent);
    mon(1, bus6.x_valid, bus6.x_out, bus6.frame_end, bus6.done, bus6.busy, bus6.frames_sent);
  end

  // Expected trace: n frames of pw bits MSB-first, g idle cycles between frames, done after the last bit.
  task automatic model(input int ch, input logic [7:0] pat, input int pw, input int n,
                       input int g, input int c_acc);
    int  t;
    ev_t e;
    t = 1;
    for (int f = 0; f < n; f++) begin
      for (int b = pw - 1; b >= 0; b--) begin
        e.stamp = c_acc + t - 1;
        e.xv = 1'b1; e.xo = pat[b]; e.fe = (b == 0); e.dn = 1'b0; e.bs = 1'b1; e.fs = 8'(f);
        if (ch == 0) q0.push_back(e); else q1.push_back(e);
        t++;
      end
      if (f < n - 1) t += g;
    end
    e.stamp = c_acc + t - 1;
    e.xv = 1'b0; e.xo = 1'b0; e.fe = 1'b0; e.dn = 1'b1; e.bs = 1'b0; e.fs = 8'(n);
    if (ch == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  int last_acc;

  task automatic set_inputs(input int ch, input logic s, input logic [7:0] pat, input int n, input int g);
    if (ch == 0) begin
      bus4.start = s; bus4.pattern = pat[3:0]; bus4.repeat_cnt = 8'(n); bus4.gap_len = 4'(g);
    end else begin
      bus6.start = s; bus6.pattern = pat[5:0]; bus6.repeat_cnt = 8'(n); bus6.gap_len = 4'(g);
    end
  endtask

  task automatic drop_start(input int ch);
    if (ch == 0) bus4.start = 1'b0; else bus6.start = 1'b0;
  endtask

  task automatic start_burst(input int ch, input logic [7:0] pat, input int n, input int g);
    set_inputs(ch, 1'b1, pat, n, g);
    last_acc = cyc + 1;
    model(ch, pat, (ch == 0) ? 4 : 6, n, g, last_acc);
    @(posedge clk); #1;
    drop_start(ch);
  endtask

  task automatic poke(input int ch, input logic [7:0] pat);
    set_inputs(ch, 1'b1, pat, $urandom_range(1, 5), $urandom_range(0, 5));
    @(posedge clk); #1;
    drop_start(ch);
  endtask

  task automatic drain(input int ch);
    int k;
    k = 0;
    while (((ch == 0) ? q0.size() : q1.size()) != 0 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if (((ch == 0) ? q0.size() : q1.size()) != 0) begin
      chk("drain_timeout", ch, 32'((ch == 0) ? q0.size() : q1.size()), 32'd0);
      if (ch == 0) q0.delete(); else q1.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    set_inputs(0, 1'b0, 8'h0, 0, 0);
    set_inputs(1, 1'b0, 8'h0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_x_valid", 0, 32'(bus4.x_valid), 32'd0);
    chk("reset_busy",    0, 32'(bus4.busy), 32'd0);
    chk("reset_done",    0, 32'(bus4.done), 32'd0);
    chk("reset_fe",      0, 32'(bus4.frame_end), 32'd0);
    chk("reset_frames",  0, 32'(bus4.frames_sent), 32'd0);
    chk("reset_busy",    1, 32'(bus6.busy), 32'd0);
    @(posedge clk); #1;

    start_burst(0, {4'h0, DEFAULT_PATTERN}, 1, 0); drain(0);
    start_burst(0, 8'h09, 3, 0); drain(0);
    start_burst(0, 8'h09, 2, 3); drain(0);
    start_burst(0, 8'h09, 0, 0); poke(0, 8'h0F); drain(0);
    start_burst(0, 8'h09, 2, 1); poke(0, 8'h0F); drain(0);

    start_burst(0, 8'h09, 4, 2);
    target = last_acc + (4 + 2 + 2) - 1;
    while (cyc < target) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    chk("abort_x_valid", 0, 32'(bus4.x_valid), 32'd0);
    chk("abort_x_out",   0, 32'(bus4.x_out), 32'd0);
    chk("abort_busy",    0, 32'(bus4.busy), 32'd0);
    chk("abort_done",    0, 32'(bus4.done), 32'd0);
    chk("abort_frames",  0, 32'(bus4.frames_sent), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    start_burst(0, 8'h09, 2, 0); drain(0);

    start_burst(1, 8'b0010_1100, 2, 1); drain(1);

    for (int i = 0; i < 40; i++) begin
      int         ch;
      logic [7:0] pat;
      ch  = int'($urandom_range(0, 1));
      pat = 8'($urandom);
      start_burst(ch, pat, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) poke(ch, 8'($urandom));
      drain(ch);
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
